// File: rtl/write_control.sv
// write_control: write-side pointer and status controller for the synchronous FIFO.
//
// Accepts producer write requests, issues the memory write strobe and the write
// pointer (MSB is the wrap bit, the low ADDR_WIDTH bits index memory), and derives
// full / almost-full / fill level against the read-side pointer. A write attempted
// while full raises a sticky overflow flag.
//
// Build option:
//   SYNC_FIFO_WR_STATUS_EN  defined   -> wr_level and a registered wr_almost_full are generated
//                           undefined -> wr_level and wr_almost_full are tied to 0
//
// Ports:
//   clk             in   system clock, rising edge
//   reset_n         in   asynchronous reset, active low
//   wr_valid        in   producer requests a write this cycle
//   rd_addr         in   read pointer (ADDR_WIDTH+1 bits) from the read-side controller
//   wr_err_clr      in   clears wr_overflow
//   wr_en           out  memory write strobe (combinational)
//   wr_addr         out  write pointer (ADDR_WIDTH+1 bits, registered)
//   wr_full         out  FIFO full (combinational from registered pointers)
//   wr_almost_full  out  level >= AFULL_THRESH (registered when enabled)
//   wr_level        out  occupancy 0..MEM_DEPTH
//   wr_overflow     out  sticky: write attempted while full (registered)

`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module write_control #(
  parameter int MEM_DEPTH    = `FIFO_DEPTH,
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int AFULL_THRESH = MEM_DEPTH - 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH:0]   rd_addr,
  input  logic                  wr_err_clr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   wr_addr,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  // Parameter sanity: depth must be a power of two >= 2 and the threshold must be
  // reachable by the level counter.
  if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) ||
      (ADDR_WIDTH != $clog2(MEM_DEPTH)) || (DATA_WIDTH < 1) ||
      (AFULL_THRESH < 1) || (AFULL_THRESH > MEM_DEPTH)) begin : g_cfg_illegal
    $error("write_control: illegal parameter combination");
  end

  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic             overflow_q, overflow_d;

  // Full when the pointers index the same slot but are on different laps.
  assign wr_full = (wr_addr_q[ADDR_WIDTH] != rd_addr[ADDR_WIDTH]) &&
                   (wr_addr_q[ADDR_WIDTH-1:0] == rd_addr[ADDR_WIDTH-1:0]);

  assign wr_en = wr_valid & ~wr_full;

  // Wrap is natural modulo-2^PTR_W overflow; the MSB toggles once per lap.
  always_comb begin
    wr_addr_d = wr_addr_q;
    if (wr_en) begin
      wr_addr_d = wr_addr_q + PTR_W'(1);
    end
  end

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_valid && wr_full) begin
      overflow_d = 1'b1;
    end else if (wr_err_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_addr     = wr_addr_q;
  assign wr_overflow = overflow_q;

`ifdef SYNC_FIFO_WR_STATUS_EN
  logic [PTR_W-1:0] next_level;
  logic             almost_full_q, almost_full_d;

  // Unsigned modulo difference; equals MEM_DEPTH exactly when full. A read
  // pointer that has overtaken the write pointer yields the raw difference.
  assign wr_level = wr_addr_q - rd_addr;

  // Almost-full is registered, evaluated on the pointer this edge will load
  // against the read pointer seen at the same edge.
  assign next_level    = wr_addr_d - rd_addr;
  assign almost_full_d = (next_level >= PTR_W'(AFULL_THRESH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign wr_almost_full = almost_full_q;
`else
  assign wr_level       = '0;
  assign wr_almost_full = 1'b0;
`endif

endmodule
